// File: rtl/hs_env_4phase.sv
// hs_env_4phase: 4-phase handshake environment for the MSFSM half-buffer controller.
// Acts as left-side source (drives Ri, consumes Ao) and right-side sink
// (consumes Ro, drives Ai). It applies programmable response delays, counts
// tokens and latches the first protocol violation.
module hs_env_4phase #(
    parameter int unsigned DELAY_W = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [CNT_W-1:0]   num_tokens,
    input  logic [DELAY_W-1:0] src_delay,
    input  logic [DELAY_W-1:0] snk_delay,
    input  logic               e_Ro_PLUS,
    input  logic               e_Ro_MINUS,
    input  logic               e_Ao_PLUS,
    input  logic               e_Ao_MINUS,
    output logic               Ri_PLUS_,
    output logic               Ri_MINUS_,
    output logic               Ai_PLUS_,
    output logic               Ai_MINUS_,
    output logic               ri,
    output logic               ai,
    output logic               ro,
    output logic               ao,
    output logic [CNT_W-1:0]   sent_cnt,
    output logic [CNT_W-1:0]   recv_cnt,
    output logic               done,
    output logic               proto_err,
    output logic [2:0]         err_code
);

    typedef enum logic [2:0] {S_IDLE, S_RISE, S_REQ, S_FALL, S_REL} src_state_t;
    typedef enum logic [1:0] {K_WAIT, K_RISE, K_ACK, K_FALL} snk_state_t;

    src_state_t         src_q, src_d;
    snk_state_t         snk_q, snk_d;
    logic [DELAY_W-1:0] src_cnt_q, src_cnt_d;
    logic [DELAY_W-1:0] snk_cnt_q, snk_cnt_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0]   sent_q, sent_d;
    logic [CNT_W-1:0]   recv_q, recv_d;
    logic               ri_q, ri_d;
    logic               ai_q, ai_d;
    logic               ro_q, ro_d;
    logic               ao_q, ao_d;
    logic               done_q, done_d;
    logic               run_q, run_d;
    logic               err_q, err_d;
    logic [2:0]         code_q, code_d;
    logic               start_ok;
    logic [2:0]         ro_code, ao_code, vcode;

    // State register: synchronous active-high reset discards any pending delay.
    always_ff @(posedge clk) begin
        if (reset) begin
            src_q     <= S_IDLE;
            snk_q     <= K_WAIT;
            src_cnt_q <= '0;
            snk_cnt_q <= '0;
            rem_q     <= '0;
            sent_q    <= '0;
            recv_q    <= '0;
            ri_q      <= 1'b0;
            ai_q      <= 1'b0;
            ro_q      <= 1'b0;
            ao_q      <= 1'b0;
            done_q    <= 1'b0;
            run_q     <= 1'b0;
            err_q     <= 1'b0;
            code_q    <= '0;
        end else begin
            src_q     <= src_d;
            snk_q     <= snk_d;
            src_cnt_q <= src_cnt_d;
            snk_cnt_q <= snk_cnt_d;
            rem_q     <= rem_d;
            sent_q    <= sent_d;
            recv_q    <= recv_d;
            ri_q      <= ri_d;
            ai_q      <= ai_d;
            ro_q      <= ro_d;
            ao_q      <= ao_d;
            done_q    <= done_d;
            run_q     <= run_d;
            err_q     <= err_d;
            code_q    <= code_d;
        end
    end

    // Source next state: a zero delay applies the ri change at the trigger edge itself.
    always_comb begin
        src_d     = src_q;
        src_cnt_d = src_cnt_q;
        rem_d     = rem_q;
        sent_d    = sent_q;
        ri_d      = ri_q;
        start_ok  = 1'b0;
        case (src_q)
            S_IDLE: begin
                if (start && (num_tokens != '0)) begin
                    start_ok = 1'b1;
                    rem_d    = num_tokens;
                    sent_d   = '0;
                    if (src_delay == '0) begin
                        ri_d  = 1'b1;
                        src_d = S_REQ;
                    end else begin
                        src_cnt_d = src_delay;
                        src_d     = S_RISE;
                    end
                end
            end
            S_RISE: begin
                if (src_cnt_q <= DELAY_W'(1)) begin
                    ri_d  = 1'b1;
                    src_d = S_REQ;
                end else begin
                    src_cnt_d = src_cnt_q - DELAY_W'(1);
                end
            end
            S_REQ: begin
                if (e_Ao_PLUS) begin
                    if (src_delay == '0) begin
                        ri_d  = 1'b0;
                        src_d = S_REL;
                    end else begin
                        src_cnt_d = src_delay;
                        src_d     = S_FALL;
                    end
                end
            end
            S_FALL: begin
                if (src_cnt_q <= DELAY_W'(1)) begin
                    ri_d  = 1'b0;
                    src_d = S_REL;
                end else begin
                    src_cnt_d = src_cnt_q - DELAY_W'(1);
                end
            end
            S_REL: begin
                if (e_Ao_MINUS) begin
                    sent_d = sent_q + CNT_W'(1);
                    rem_d  = rem_q - CNT_W'(1);
                    if (rem_d == '0) begin
                        src_d = S_IDLE;
                    end else if (src_delay == '0) begin
                        ri_d  = 1'b1;
                        src_d = S_REQ;
                    end else begin
                        src_cnt_d = src_delay;
                        src_d     = S_RISE;
                    end
                end
            end
            default: src_d = S_IDLE;
        endcase
    end

    // Sink next state: always armed; ai follows Ro events after the sink delay.
    always_comb begin
        snk_d     = snk_q;
        snk_cnt_d = snk_cnt_q;
        recv_d    = recv_q;
        ai_d      = ai_q;
        case (snk_q)
            K_WAIT: begin
                if (e_Ro_PLUS) begin
                    if (snk_delay == '0) begin
                        ai_d  = 1'b1;
                        snk_d = K_ACK;
                    end else begin
                        snk_cnt_d = snk_delay;
                        snk_d     = K_RISE;
                    end
                end
            end
            K_RISE: begin
                if (snk_cnt_q <= DELAY_W'(1)) begin
                    ai_d  = 1'b1;
                    snk_d = K_ACK;
                end else begin
                    snk_cnt_d = snk_cnt_q - DELAY_W'(1);
                end
            end
            K_ACK: begin
                if (e_Ro_MINUS) begin
                    if (snk_delay == '0) begin
                        ai_d   = 1'b0;
                        recv_d = recv_q + CNT_W'(1);
                        snk_d  = K_WAIT;
                    end else begin
                        snk_cnt_d = snk_delay;
                        snk_d     = K_FALL;
                    end
                end
            end
            K_FALL: begin
                if (snk_cnt_q <= DELAY_W'(1)) begin
                    ai_d   = 1'b0;
                    recv_d = recv_q + CNT_W'(1);
                    snk_d  = K_WAIT;
                end else begin
                    snk_cnt_d = snk_cnt_q - DELAY_W'(1);
                end
            end
            default: snk_d = K_WAIT;
        endcase
    end

    // Mirror levels, first-violation capture and run completion.
    // A +/- pair on one signal is reported as code 5 in place of that signal's
    // level checks; otherwise a clean pair could never be distinguished.
    always_comb begin
        ro_d = e_Ro_PLUS ? 1'b1 : (e_Ro_MINUS ? 1'b0 : ro_q);
        ao_d = e_Ao_PLUS ? 1'b1 : (e_Ao_MINUS ? 1'b0 : ao_q);

        ro_code = 3'd0;
        if (e_Ro_PLUS && e_Ro_MINUS)                     ro_code = 3'd5;
        else if (e_Ro_PLUS && (ro_q || !ri_q || ai_q))   ro_code = 3'd1;
        else if (e_Ro_MINUS && (!ro_q || !ai_q))         ro_code = 3'd2;

        ao_code = 3'd0;
        if (e_Ao_PLUS && e_Ao_MINUS)                     ao_code = 3'd5;
        else if (e_Ao_PLUS && (ao_q || !ri_q))           ao_code = 3'd3;
        else if (e_Ao_MINUS && (!ao_q || ri_q))          ao_code = 3'd4;

        if (ro_code != 3'd0 && (ao_code == 3'd0 || ro_code <= ao_code)) vcode = ro_code;
        else                                                            vcode = ao_code;

        err_d  = err_q;
        code_d = code_q;
        if (!err_q && vcode != 3'd0) begin
            err_d  = 1'b1;
            code_d = vcode;
        end

        done_d = done_q;
        run_d  = run_q;
        if (start_ok) begin
            done_d = 1'b0;
            run_d  = 1'b1;
        end else if (run_q && src_d == S_IDLE && recv_d == sent_d && !ai_d) begin
            done_d = 1'b1;
            run_d  = 1'b0;
        end
    end

    // Outputs: all taken directly from registers.
    always_comb begin
        ri        = ri_q;
        ai        = ai_q;
        ro        = ro_q;
        ao        = ao_q;
        Ri_PLUS_  = ri_q;
        Ri_MINUS_ = ~ri_q;
        Ai_PLUS_  = ai_q;
        Ai_MINUS_ = ~ai_q;
        sent_cnt  = sent_q;
        recv_cnt  = recv_q;
        done      = done_q;
        proto_err = err_q;
        err_code  = code_q;
    end

endmodule

// File: tb/tb_hs_env_4phase.sv
// tb_hs_env_4phase: directed scoreboard bench for hs_env_4phase.
// Stimulus pushes expected ri/ai edges, error captures and run completions
// into queues; a negedge monitor pops and compares whenever the DUT shows one.
module tb_hs_env_4phase;

    localparam int DW = 4;
    localparam int CW = 16;
    localparam int RO_P = 0, RO_M = 1, AO_P = 2, AO_M = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [CW-1:0] num_tokens;
    logic [DW-1:0] src_delay, snk_delay;
    logic          e_Ro_PLUS, e_Ro_MINUS, e_Ao_PLUS, e_Ao_MINUS;
    logic          Ri_PLUS_, Ri_MINUS_, Ai_PLUS_, Ai_MINUS_;
    logic          ri, ai, ro, ao;
    logic [CW-1:0] sent_cnt, recv_cnt;
    logic          done, proto_err;
    logic [2:0]    err_code;

    hs_env_4phase #(.DELAY_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .num_tokens(num_tokens),
        .src_delay(src_delay), .snk_delay(snk_delay),
        .e_Ro_PLUS(e_Ro_PLUS), .e_Ro_MINUS(e_Ro_MINUS),
        .e_Ao_PLUS(e_Ao_PLUS), .e_Ao_MINUS(e_Ao_MINUS),
        .Ri_PLUS_(Ri_PLUS_), .Ri_MINUS_(Ri_MINUS_),
        .Ai_PLUS_(Ai_PLUS_), .Ai_MINUS_(Ai_MINUS_),
        .ri(ri), .ai(ai), .ro(ro), .ao(ao),
        .sent_cnt(sent_cnt), .recv_cnt(recv_cnt),
        .done(done), .proto_err(proto_err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct { int edge_n; logic val; }           lvl_exp_t;
    typedef struct { int edge_n; int code; }            err_exp_t;
    typedef struct { int edge_n; int sent; int recv; }  done_exp_t;

    lvl_exp_t  exp_ri[$];
    lvl_exp_t  exp_ai[$];
    err_exp_t  exp_err[$];
    done_exp_t exp_done[$];

    bit mon_en  = 1'b0;
    bit lvl_chk = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: got unexpected DUT activity at edge %0d, expected none", name, cyc);
    endtask

    // Monitor: pops expectations whenever a watched output changes.
    logic      ri_p, ai_p, err_p, done_p;
    lvl_exp_t  m_lvl;
    err_exp_t  m_err;
    done_exp_t m_done;
    always @(negedge clk) begin
        if (mon_en) begin
            if (ri !== ri_p && lvl_chk) begin
                if (exp_ri.size() == 0) flag("ri_edge");
                else begin
                    m_lvl = exp_ri.pop_front();
                    check("ri_edge_time", cyc, m_lvl.edge_n);
                    check("ri_edge_level", ri, m_lvl.val);
                end
            end
            if (ai !== ai_p && lvl_chk) begin
                if (exp_ai.size() == 0) flag("ai_edge");
                else begin
                    m_lvl = exp_ai.pop_front();
                    check("ai_edge_time", cyc, m_lvl.edge_n);
                    check("ai_edge_level", ai, m_lvl.val);
                end
            end
            if (proto_err === 1'b1 && err_p !== 1'b1) begin
                if (exp_err.size() == 0) flag("proto_err_rise");
                else begin
                    m_err = exp_err.pop_front();
                    check("err_time", cyc, m_err.edge_n);
                    check("err_code", err_code, m_err.code);
                end
            end
            if (done === 1'b1 && done_p !== 1'b1) begin
                if (exp_done.size() == 0) flag("done_rise");
                else begin
                    m_done = exp_done.pop_front();
                    if (m_done.edge_n >= 0) check("done_time", cyc, m_done.edge_n);
                    check("done_sent", sent_cnt, m_done.sent);
                    check("done_recv", recv_cnt, m_done.recv);
                end
            end
        end
        ri_p   = ri;
        ai_p   = ai;
        err_p  = proto_err;
        done_p = done;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int edge_n);
        while (cyc < edge_n) @(negedge clk);
    endtask

    task automatic pulse(input int sel);
        case (sel)
            RO_P: e_Ro_PLUS  = 1'b1;
            RO_M: e_Ro_MINUS = 1'b1;
            AO_P: e_Ao_PLUS  = 1'b1;
            default: e_Ao_MINUS = 1'b1;
        endcase
        @(negedge clk);
        e_Ro_PLUS = 1'b0; e_Ro_MINUS = 1'b0; e_Ao_PLUS = 1'b0; e_Ao_MINUS = 1'b0;
    endtask

    task automatic wait_lvl(input int sel, input logic val, input string name);
        int n = 0;
        while (((sel == 0) ? ri : ai) !== val && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: timeout, level still %0b, expected %0b", name, (sel == 0) ? ri : ai, val);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    int c;
    initial begin
        reset = 1'b1; start = 1'b0; num_tokens = '0; src_delay = '0; snk_delay = '0;
        e_Ro_PLUS = 1'b0; e_Ro_MINUS = 1'b0; e_Ao_PLUS = 1'b0; e_Ao_MINUS = 1'b0;
        step(3);
        reset = 1'b0;
        step(1);

        // Reset state
        check("rst_ri", ri, 0);            check("rst_ai", ai, 0);
        check("rst_ro", ro, 0);            check("rst_ao", ao, 0);
        check("rst_Ri_PLUS", Ri_PLUS_, 0); check("rst_Ri_MINUS", Ri_MINUS_, 1);
        check("rst_Ai_PLUS", Ai_PLUS_, 0); check("rst_Ai_MINUS", Ai_MINUS_, 1);
        check("rst_sent", sent_cnt, 0);    check("rst_recv", recv_cnt, 0);
        check("rst_done", done, 0);        check("rst_err", proto_err, 0);
        check("rst_code", err_code, 0);
        mon_en = 1'b1;

        // Standalone source, D_s=3
        src_delay = 4'd3; num_tokens = 16'd1;
        c = cyc; start = 1'b1;
        exp_ri.push_back(lvl_exp_t'{c + 4, 1'b1});
        step(1); start = 1'b0;
        wait_until(c + 5);
        c = cyc;
        exp_ri.push_back(lvl_exp_t'{c + 4, 1'b0});
        pulse(AO_P);
        wait_until(c + 5);
        pulse(AO_M);
        check("src_sent_one", sent_cnt, 1);
        check("src_done_waits_sink", done, 0);

        // Sink D_k=2 with ri high; sink lags so done follows the ai fall
        src_delay = 4'd0; snk_delay = 4'd2; num_tokens = 16'd1;
        c = cyc; start = 1'b1;
        exp_ri.push_back(lvl_exp_t'{c + 1, 1'b1});
        step(1); start = 1'b0;
        check("start_clears_sent", sent_cnt, 0);
        c = cyc;
        exp_ai.push_back(lvl_exp_t'{c + 3, 1'b1});
        pulse(RO_P);
        check("ro_mirror_set", ro, 1);
        wait_until(c + 4);
        c = cyc;
        exp_ri.push_back(lvl_exp_t'{c + 1, 1'b0});
        pulse(AO_P);
        pulse(AO_M);
        check("lag_sent", sent_cnt, 1);
        check("lag_recv", recv_cnt, 0);
        check("lag_done_low", done, 0);
        c = cyc;
        exp_ai.push_back(lvl_exp_t'{c + 3, 1'b0});
        exp_done.push_back(done_exp_t'{c + 3, 1, 1});
        pulse(RO_M);
        wait_until(c + 4);
        check("sink_recv_one", recv_cnt, 1);
        check("lag_done_set", done, 1);
        check("ro_mirror_clr", ro, 0);
        check("ao_mirror_clr", ao, 0);
        check("clean_no_err", proto_err, 0);

        // Violations: code 2 latched, later code 4 ignored
        c = cyc;
        exp_err.push_back(err_exp_t'{c + 1, 2});
        pulse(RO_M);
        step(1);
        pulse(AO_M);
        step(1);
        check("first_err_kept", err_code, 2);
        check("err_sticky", proto_err, 1);

        // Same-cycle Ao pair -> code 5; zero-token start ignored
        do_reset();
        check("reset_clears_err", proto_err, 0);
        c = cyc;
        exp_err.push_back(err_exp_t'{c + 1, 5});
        e_Ao_PLUS = 1'b1; e_Ao_MINUS = 1'b1;
        step(1);
        e_Ao_PLUS = 1'b0; e_Ao_MINUS = 1'b0;
        step(1);
        num_tokens = 16'd0; start = 1'b1;
        step(1); start = 1'b0;
        step(8);
        check("zero_tok_done", done, 0);
        check("zero_tok_ri", ri, 0);

        // Reset in S_FALL with a pending delay
        do_reset();
        src_delay = 4'd0; num_tokens = 16'd3;
        c = cyc; start = 1'b1;
        exp_ri.push_back(lvl_exp_t'{c + 1, 1'b1});
        step(1); start = 1'b0;
        src_delay = 4'd4;
        pulse(AO_P);
        step(1);
        c = cyc;
        exp_ri.push_back(lvl_exp_t'{c + 1, 1'b0});
        do_reset();
        step(10);
        check("midrst_ri", ri, 0);
        check("midrst_sent", sent_cnt, 0);
        check("midrst_recv", recv_cnt, 0);
        check("midrst_err", proto_err, 0);

        // Loopback with a behavioural controller, 5 tokens, zero delays
        do_reset();
        src_delay = 4'd0; snk_delay = 4'd0; num_tokens = 16'd5;
        lvl_chk = 1'b0;
        exp_done.push_back(done_exp_t'{-1, 5, 5});
        start = 1'b1;
        step(1); start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            wait_lvl(0, 1'b1, "lb_ri_rise");
            pulse(RO_P);
            wait_lvl(1, 1'b1, "lb_ai_rise");
            pulse(AO_P);
            wait_lvl(0, 1'b0, "lb_ri_fall");
            pulse(RO_M);
            wait_lvl(1, 1'b0, "lb_ai_fall");
            pulse(AO_M);
        end
        step(1);
        lvl_chk = 1'b1;
        check("lb_sent", sent_cnt, 5);
        check("lb_recv", recv_cnt, 5);
        check("lb_done", done, 1);
        check("lb_err", proto_err, 0);
        check("lb_ri", ri, 0);
        check("lb_ai", ai, 0);

        step(2);
        check("ri_queue_drained", exp_ri.size(), 0);
        check("ai_queue_drained", exp_ai.size(), 0);
        check("err_queue_drained", exp_err.size(), 0);
        check("done_queue_drained", exp_done.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hs_env_4phase.md
# hs_env_4phase

Synthesizable 4-phase handshake environment that drives the opposite end of the Mealy MSFSM half-buffer controller. It acts as the left-side source, generating Ri and consuming Ao, and as the right-side sink, consuming Ro and generating Ai. It turns the controller's single-cycle `e_*` output events into level-derived `*_PLUS_`/`*_MINUS_` input conditions, with programmable response delays. It counts tokens and flags protocol violations, so the controller can be closed-loop tested on FPGA or in simulation.

## Interface
- `DELAY_W`, default 4: width of the response-delay inputs.
- `CNT_W`, default 16: width of the token count and counters.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  reset, synchronous, active-high; clock clk.
- `start`  in  1  pulse; begins a run of `num_tokens` tokens when the source is idle.
- `num_tokens`  in  CNT_W  tokens per run; sampled on accepted `start`.
- `src_delay`  in  DELAY_W  source response delay D_s (cycles).
- `snk_delay`  in  DELAY_W  sink response delay D_k (cycles).
- `e_Ro_PLUS`, `e_Ro_MINUS`, `e_Ao_PLUS`, `e_Ao_MINUS`  in  1 each  controller event pulses.
- `Ri_PLUS_`, `Ri_MINUS_`  out  1 each  equal to `ri` / `~ri`.
- `Ai_PLUS_`, `Ai_MINUS_`  out  1 each  equal to `ai` / `~ai`.
- `ri`, `ai`  out  1 each  registered handshake wire levels.
- `ro`, `ao`  out  1 each  mirrored controller levels, toggled by events.
- `sent_cnt`, `recv_cnt`  out  CNT_W each  completed source / sink cycles.
- `done`  out  1  run complete.
- `proto_err`  out  1  sticky violation flag.
- `err_code`  out  3  code of the first violation.

## Operation
- Delay rule: a trigger is sampled at edge E. The response level changes at edge E+D. With D=0 the change happens at E itself and is visible the following cycle. The delay counter is loaded with D on the trigger.
- Source FSM states: S_IDLE, S_RISE, S_REQ, S_FALL, S_REL.
  - S_IDLE: `start` with `num_tokens`≠0 latches `rem`=`num_tokens`, clears `sent_cnt` and `done`, then goes to S_RISE (delay D_s). `start` in any other state, or with `num_tokens`=0, is ignored.
  - S_RISE: when the delay expires, `ri`←1 and go to S_REQ.
  - S_REQ: `e_Ao_PLUS` → S_FALL (delay D_s).
  - S_FALL: when the delay expires, `ri`←0 and go to S_REL.
  - S_REL: `e_Ao_MINUS` → `sent_cnt`+1 and `rem`−1. If `rem` becomes 0, go to S_IDLE; otherwise go to S_RISE.
- Sink FSM states: K_WAIT, K_RISE, K_ACK, K_FALL. The sink is always active after reset.
  - K_WAIT: `e_Ro_PLUS` → K_RISE (delay D_k).
  - K_RISE: `ai`←1, go to K_ACK.
  - K_ACK: `e_Ro_MINUS` → K_FALL (delay D_k).
  - K_FALL: `ai`←0, `recv_cnt`+1, go to K_WAIT.
- `done` is set on the edge at which the source returns to S_IDLE and `recv_cnt`==`sent_cnt` with `ai`=0. If the sink lags, `done` is set on the first later edge where that condition holds. `done` is cleared by an accepted `start`.
- Mirror levels: `ro` is set by `e_Ro_PLUS` and cleared by `e_Ro_MINUS`. `ao` is handled the same way with the Ao events.
- Violations: only the first violation is latched into `err_code`; `proto_err` stays set until reset. Codes:
  - 1: `e_Ro_PLUS` with `ro`=1, `ri`=0, or `ai`=1.
  - 2: `e_Ro_MINUS` with `ro`=0 or `ai`=0.
  - 3: `e_Ao_PLUS` with `ao`=1 or `ri`=0.
  - 4: `e_Ao_MINUS` with `ao`=0 or `ri`=1.
  - 5: a `+` and a `−` event on the same signal in the same cycle.
  - If several violations occur in one cycle, the lowest code wins.
- A violating event still updates the mirror level and the FSMs. The error does not stall the environment.
- Counters wrap modulo 2^CNT_W.

## Timing
- Reset values:
  - `ri`=`ai`=`ro`=`ao`=0, so `Ri_PLUS_`=0, `Ri_MINUS_`=1, `Ai_PLUS_`=0, `Ai_MINUS_`=1.
  - Counters 0, `done`=0, `proto_err`=0, `err_code`=0.
  - FSMs in S_IDLE and K_WAIT.
- Reset mid-run: all of the above apply at the reset edge, and any pending delay is discarded.
- All outputs are registered; there is no combinational path from `e_*` to any output.
- Source and sink are independent. Simultaneous `e_Ao_*` and `e_Ro_*` events in one cycle are both processed at that edge.
- `src_delay` and `snk_delay` are sampled at each trigger. Changes mid-delay take effect at the next trigger.
- A minimum source token cycle takes 2 edges plus the controller's event latencies.

## Test plan
- Loopback to the controller, `num_tokens`=5, D_s=D_k=0 → `sent_cnt`=`recv_cnt`=5, `done`=1, `proto_err`=0, final `ri`=`ai`=0.
- Standalone, D_s=3: `start` at E0 → `ri` rises at E0+3. Pulse `e_Ao_PLUS` at E1 → `ri` falls at E1+3. Pulse `e_Ao_MINUS` → `sent_cnt`=1.
- Sink, D_k=2, `ri`=1 established: `e_Ro_PLUS` at E → `ai`=1 at E+2. `e_Ro_MINUS` at F → `ai`=0 at F+2 and `recv_cnt`=1.
- `e_Ro_MINUS` pulsed with `ro`=0 → `proto_err`=1, `err_code`=2. A later code-4 violation leaves `err_code` at 2.
- `e_Ao_PLUS` and `e_Ao_MINUS` in the same cycle → `err_code`=5. `start` with `num_tokens`=0 → no `ri` activity and `done` stays 0.
- Reset asserted in S_FALL with a pending delay → `ri`=0, counters 0, and no `ri` edge afterwards until a new `start`.
